// File: rtl/bus_ram_responder_pkg.sv
// rtl/bus_ram_responder_pkg.sv - shared encodings for the bus RAM responder
package bus_ram_responder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Also used by the CPU bus access block.
  localparam logic BUS_RW_READ  = 1'b0;
  localparam logic BUS_RW_WRITE = 1'b1;

  localparam int WAIT_CNT_BITS = 4;
  localparam int DATA_BITS     = 32;

endpackage

// File: rtl/bus_ram_responder_if.sv
// rtl/bus_ram_responder_if.sv - single-master request/ready bus
interface bus_ram_responder_if;
  import bus_ram_responder_pkg::*;

  logic                 rw;
  logic                 request;
  logic                 ready;
  logic [31:0]          address;
  logic [DATA_BITS-1:0] rdata;
  logic [DATA_BITS-1:0] wdata;

  modport master (output rw, request, address, wdata, input ready, rdata);
  modport slave  (input rw, request, address, wdata, output ready, rdata);

endinterface

// File: rtl/bus_ram_array.sv
// rtl/bus_ram_array.sv - single-port synchronous RAM, 1-cycle read, no reset
module bus_ram_array
  import bus_ram_responder_pkg::*;
#(
  parameter int ADDR_BITS = 12
) (
  input  logic                 clock,
  input  logic                 enable,
  input  logic                 write_enable,
  input  logic [ADDR_BITS-1:0] address,
  input  logic [DATA_BITS-1:0] wdata,
  output logic [DATA_BITS-1:0] rdata
);

  logic [DATA_BITS-1:0] mem [2**ADDR_BITS];

  always_ff @(posedge clock) begin
    if (enable) begin
      if (write_enable) mem[address] <= wdata;
      else              rdata        <= mem[address];
    end
  end

endmodule

// File: rtl/bus_ram_responder.sv
// rtl/bus_ram_responder.sv - bus target RAM with wait states and window decode
module bus_ram_responder
  import bus_ram_responder_pkg::*;
#(
  parameter int          ADDR_BITS    = 12,
  parameter int          WAIT_STATES  = 2,
  parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000
) (
  input  logic                i_clock,
  input  logic                i_reset,
  bus_ram_responder_if.slave  bus
);

  state_t                   state_q, state_d;
  logic [WAIT_CNT_BITS-1:0] cnt_q, cnt_d;
  logic                     accept;
  logic                     rw_q;
  logic [31:2]              addr_q;
  logic [DATA_BITS-1:0]     wdata_q;
  logic                     ready_q;
  logic                     rd_valid_q;
  logic                     hit;
  logic                     ram_en;
  logic                     ram_we;
  logic [DATA_BITS-1:0]     ram_rdata;

  assign hit = (addr_q[31:ADDR_BITS+2] == BASE_ADDRESS[31:ADDR_BITS+2]);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    ram_en  = 1'b0;
    ram_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.request) begin
          accept = 1'b1;
          if (WAIT_STATES > 0) begin
            state_d = WAIT;
            cnt_d   = WAIT_CNT_BITS'(WAIT_STATES - 1);
          end else begin
            state_d = ACCESS;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = ACCESS;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ACCESS: begin
        ram_en  = hit;
        ram_we  = hit && (rw_q == BUS_RW_WRITE);
        state_d = DONE;
      end
      DONE: begin
        if (!bus.request) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ready_q    <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= (state_d == DONE);
      // The RAM output register only carries the answer for hit reads;
      // misses and writes must present zero.
      if (state_q == ACCESS)  rd_valid_q <= hit && (rw_q == BUS_RW_READ);
      else if (state_d != DONE) rd_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge i_clock) begin
    if (accept) begin
      rw_q    <= bus.rw;
      addr_q  <= bus.address[31:2];
      wdata_q <= bus.wdata;
    end
  end

  bus_ram_array #(.ADDR_BITS(ADDR_BITS)) u_array (
    .clock        (i_clock),
    .enable       (ram_en),
    .write_enable (ram_we),
    .address      (addr_q[ADDR_BITS+1:2]),
    .wdata        (wdata_q),
    .rdata        (ram_rdata)
  );

  assign bus.ready = ready_q;
  assign bus.rdata = rd_valid_q ? ram_rdata : '0;

endmodule

// File: tb/tb_bus_ram_responder.sv
// tb/tb_bus_ram_responder.sv - scoreboard bench over three responder configurations
module tb_bus_ram_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rw  = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] wdata = '0;
  logic [2:0]  req = '0;
  int          sel = 0;
  logic        cur_ready;
  logic [31:0] cur_rdata;

  logic [31:0] exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  bus_ram_responder_if bus0 ();
  bus_ram_responder_if bus1 ();
  bus_ram_responder_if bus2 ();

  assign bus0.rw = rw;  assign bus0.address = address;  assign bus0.wdata = wdata;  assign bus0.request = req[0];
  assign bus1.rw = rw;  assign bus1.address = address;  assign bus1.wdata = wdata;  assign bus1.request = req[1];
  assign bus2.rw = rw;  assign bus2.address = address;  assign bus2.wdata = wdata;  assign bus2.request = req[2];

  bus_ram_responder #(.ADDR_BITS(12), .WAIT_STATES(2), .BASE_ADDRESS(32'h0000_0000))
    dut0 (.i_clock(clk), .i_reset(rst), .bus(bus0));
  bus_ram_responder #(.ADDR_BITS(12), .WAIT_STATES(0), .BASE_ADDRESS(32'h0000_0000))
    dut1 (.i_clock(clk), .i_reset(rst), .bus(bus1));
  bus_ram_responder #(.ADDR_BITS(12), .WAIT_STATES(2), .BASE_ADDRESS(32'h0001_0000))
    dut2 (.i_clock(clk), .i_reset(rst), .bus(bus2));

  always_comb begin
    cur_ready = 1'b0;
    cur_rdata = '0;
    case (sel)
      0: begin cur_ready = bus0.ready; cur_rdata = bus0.rdata; end
      1: begin cur_ready = bus1.ready; cur_rdata = bus1.rdata; end
      2: begin cur_ready = bus2.ready; cur_rdata = bus2.rdata; end
      default: ;
    endcase
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One full transaction; expected rdata is queued at drive time, popped at ready.
  task automatic run_txn(input int s, input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] exp_rdata, input int exp_lat, input bit churn,
                         input string tag);
    int cycles;
    logic [31:0] e;
    @(negedge clk);
    sel = s; rw = w; address = a; wdata = d;
    exp_q.push_back(w ? 32'h0 : exp_rdata);
    req[s] = 1'b1;
    cycles = 0;
    do begin
      @(posedge clk); #1;
      cycles++;
      if (!cur_ready && churn) begin
        address = $urandom; wdata = $urandom; rw = ~rw;
      end
    end while (!cur_ready && cycles < 40);
    check_eq({tag, "_ready"}, {31'b0, cur_ready}, 32'd1);
    check_eq({tag, "_latency"}, cycles, exp_lat);
    e = exp_q.pop_front();
    check_eq({tag, "_rdata"}, cur_rdata, e);
    @(posedge clk); #1;
    check_eq({tag, "_hold_rdata"}, cur_rdata, e);
    @(negedge clk);
    req[s] = 1'b0;
    @(posedge clk); #1;
    check_eq({tag, "_release_ready"}, {31'b0, cur_ready}, 32'd0);
    check_eq({tag, "_release_rdata"}, cur_rdata, 32'd0);
  endtask

  initial begin
    int pulses;
    int width;
    int max_width;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ready0", {31'b0, bus0.ready}, 0);  check_eq("rst_rdata0", bus0.rdata, 0);
    check_eq("rst_ready1", {31'b0, bus1.ready}, 0);  check_eq("rst_rdata1", bus1.rdata, 0);
    check_eq("rst_ready2", {31'b0, bus2.ready}, 0);  check_eq("rst_rdata2", bus2.rdata, 0);
    @(negedge clk);
    rst = 1'b0;

    // WAIT_STATES=2: preload word 5 then read it back
    run_txn(0, 1'b1, 32'h0000_0014, 32'hDEAD_BEEF, 0, 4, 0, "w2_preload");
    run_txn(0, 1'b0, 32'h0000_0014, 0, 32'hDEAD_BEEF, 4, 0, "w2_read");

    // WAIT_STATES=0: write then read
    run_txn(1, 1'b1, 32'h0000_0100, 32'h1234_5678, 0, 2, 0, "w0_write");
    run_txn(1, 1'b0, 32'h0000_0100, 0, 32'h1234_5678, 2, 0, "w0_read");

    // Window decode with base 0x0001_0000
    run_txn(2, 1'b1, 32'h0001_0000, 32'hCAFE_F00D, 0, 4, 0, "win_w0");
    run_txn(2, 1'b1, 32'h0001_3FFC, 32'h0F0F_1234, 0, 4, 0, "win_wlast");
    run_txn(2, 1'b0, 32'h0002_0000, 0, 32'h0, 4, 0, "oow_read");
    run_txn(2, 1'b1, 32'h0002_0000, 32'hFFFF_FFFF, 0, 4, 0, "oow_write");
    run_txn(2, 1'b1, 32'h0001_4000, 32'h5A5A_5A5A, 0, 4, 0, "oow_edge_write");
    run_txn(2, 1'b0, 32'h0001_0000, 0, 32'hCAFE_F00D, 4, 0, "win_r0");
    run_txn(2, 1'b0, 32'h0001_3FFF, 0, 32'h0F0F_1234, 4, 0, "win_rlast");

    // Input churn after acceptance
    run_txn(0, 1'b1, 32'h0000_0040, 32'h0BAD_F00D, 0, 4, 1, "churn_write");
    run_txn(0, 1'b0, 32'h0000_0040, 0, 32'h0BAD_F00D, 4, 1, "churn_read");
    run_txn(1, 1'b0, 32'h0000_0100, 0, 32'h1234_5678, 2, 1, "churn_read_w0");

    // Reset during the wait phase of a write
    run_txn(0, 1'b1, 32'h0000_000C, 32'hAAAA_AAAA, 0, 4, 0, "rst_pre");
    @(negedge clk);
    sel = 0; rw = 1'b1; address = 32'h0000_000C; wdata = 32'h5555_5555; req[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1; req[0] = 1'b0;
    @(posedge clk); #1;
    check_eq("midrst_ready", {31'b0, bus0.ready}, 0);
    check_eq("midrst_rdata", bus0.rdata, 0);
    @(negedge clk);
    rst = 1'b0;
    run_txn(0, 1'b0, 32'h0000_000C, 0, 32'hAAAA_AAAA, 4, 0, "midrst_read");

    // Request held for a single cycle only
    @(negedge clk);
    sel = 0; rw = 1'b0; address = 32'h0000_0014; req[0] = 1'b1;
    exp_q.push_back(32'hDEAD_BEEF);
    @(negedge clk);
    req[0] = 1'b0;
    pulses = 0; width = 0; max_width = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (cur_ready) begin
        if (width == 0) begin
          pulses++;
          check_eq("early_rdata", cur_rdata, exp_q.pop_front());
        end
        width++;
        if (width > max_width) max_width = width;
      end else begin
        width = 0;
      end
    end
    check_eq("early_pulses", pulses, 1);
    check_eq("early_width", max_width, 1);
    run_txn(0, 1'b0, 32'h0000_0014, 0, 32'hDEAD_BEEF, 4, 0, "after_early");

    check_eq("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
